// File: rtl/timer_mch.sv
`timescale 1ns/1ps
// timer_mch: N_CH independent prescaled counters with compare, modes and sticky IRQs, behind a zero-wait APB slave.
// Latency: APB reads combinational in the access cycle; writes commit on the edge ending the access; CNT moves one cycle after a tick.
// Backpressure: none, tim_pready = tim_psel & tim_penable; bad accesses answer with tim_pslverr and have no effect.
//
// Ports: sys_clk/sys_rst_n (async active-low); tim_p* APB slave (12-bit byte address);
//        dbg_mode from the core for the halt handshake; tim_int[N_CH] level interrupts.
module timer_mch #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            tim_psel,
    input  logic            tim_penable,
    input  logic            tim_pwrite,
    input  logic [3:0]      tim_pstrb,
    input  logic [31:0]     tim_pwdata,
    input  logic [11:0]     tim_paddr,
    input  logic            dbg_mode,
    output logic [31:0]     tim_prdata,
    output logic            tim_pready,
    output logic            tim_pslverr,
    output logic [N_CH-1:0] tim_int
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Byte-lane merge of write data over the current register image.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

    // ---------------- address decode ----------------
    logic       access;
    logic [7:0] ch_idx;
    logic [1:0] ofs;
    logic       halt_sel;
    logic       ch_hit;

    assign access   = tim_psel & tim_penable;
    assign ch_idx   = tim_paddr[11:4];
    assign ofs      = tim_paddr[3:2];
    assign halt_sel = (tim_paddr[11:2] == 10'h3C0);
    assign ch_hit   = (ch_idx < 8'(N_CH));

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, tim_paddr[1:0]};

    // ---------------- global halt handshake ----------------
    logic halt_req;
    logic halt_ack;

    // ---------------- read images from the channels ----------------
    logic [31:0] ctrl_rd [N_CH];
    logic [31:0] cnt_rd  [N_CH];
    logic [31:0] cmp_rd  [N_CH];
    logic [31:0] int_rd  [N_CH];

    logic [31:0] rd_raw;

    always_comb begin
        rd_raw = '0;
        if (halt_sel) begin
            rd_raw = {30'd0, halt_ack, halt_req};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_idx == 8'(i)) begin
                    case (ofs)
                        2'd0:    rd_raw = ctrl_rd[i];
                        2'd1:    rd_raw = cnt_rd[i];
                        2'd2:    rd_raw = cmp_rd[i];
                        default: rd_raw = int_rd[i];
                    endcase
                end
            end
        end
    end

    // The addressed register's image merged with the strobed write bytes; only
    // the addressed register consumes it, so one merge serves every RW field.
    logic [31:0] wd;
    logic        bad_ctrl;
    logic        err;
    logic        wr;

    assign wd       = merge_bytes(rd_raw, tim_pwdata, tim_pstrb);
    assign bad_ctrl = (wd[11:8] > 4'd8) || (wd[2:1] == 2'b11);
    assign err      = !halt_sel && (!ch_hit || (tim_pwrite && ofs == 2'd0 && bad_ctrl));
    assign wr       = access & tim_pwrite & ~err;

    assign tim_pready  = access;
    assign tim_pslverr = access & err;
    assign tim_prdata  = (access && !err) ? rd_raw : 32'd0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            halt_req <= 1'b0;
            halt_ack <= 1'b0;
        end else begin
            if (wr && halt_sel && tim_pstrb[0]) begin
                halt_req <= tim_pwdata[0];
            end
            halt_ack <= halt_req & dbg_mode;
        end
    end

    // ---------------- channels ----------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic             en;
        logic [1:0]       mode;
        logic             dbg_stop;
        logic [3:0]       div;
        logic [7:0]       div_cnt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cmp;
        logic             int_st;
        logic             int_en;

        logic       wr_ch;
        logic       wr_ctrl;
        logic       wr_cnt;
        logic       wr_cmp;
        logic       wr_int;
        logic       frozen;
        logic [7:0] div_mask;
        logic       tick;
        logic       match;

        assign wr_ch   = wr && !halt_sel && (ch_idx == 8'(gi));
        assign wr_ctrl = wr_ch && (ofs == 2'd0);
        assign wr_cnt  = wr_ch && (ofs == 2'd1);
        assign wr_cmp  = wr_ch && (ofs == 2'd2);
        assign wr_int  = wr_ch && (ofs == 2'd3);

        assign frozen   = halt_ack & dbg_stop;
        // DIV never exceeds 8 (rejected on write), so the mask fits 8 bits.
        assign div_mask = 8'((9'd1 << div) - 9'd1);
        assign tick     = en && !frozen && (div_cnt == div_mask);
        assign match    = (cnt == cmp);

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                en       <= 1'b0;
                mode     <= 2'b00;
                dbg_stop <= 1'b0;
                div      <= 4'd0;
                div_cnt  <= 8'd0;
                cnt      <= '0;
                cmp      <= '1;
                int_st   <= 1'b0;
                int_en   <= 1'b0;
            end else begin
                if (wr_ctrl || !en || frozen || tick) begin
                    div_cnt <= 8'd0;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end

                // A CTRL write overrides the one-shot auto-disable.
                if (wr_ctrl) begin
                    en       <= wd[0];
                    mode     <= wd[2:1];
                    dbg_stop <= wd[3];
                    div      <= wd[11:8];
                end else if (tick && match && mode == 2'b10) begin
                    en <= 1'b0;
                end

                // A CNT write overrides the tick update.
                if (wr_cnt) begin
                    cnt <= wd[CNT_W-1:0];
                end else if (tick) begin
                    cnt <= (match && mode != 2'b00) ? '0 : cnt + CNT_ONE;
                end

                if (wr_cmp) begin
                    cmp <= wd[CNT_W-1:0];
                end

                // Setting on a match beats a simultaneous W1C.
                if (tick && match) begin
                    int_st <= 1'b1;
                end else if (wr_int && tim_pstrb[0] && tim_pwdata[0]) begin
                    int_st <= 1'b0;
                end

                if (wr_int && tim_pstrb[0]) begin
                    int_en <= tim_pwdata[1];
                end
            end
        end

        assign tim_int[gi] = int_st & int_en;

        always_comb begin
            cnt_rd[gi] = '0;
            cmp_rd[gi] = '0;
            cnt_rd[gi][CNT_W-1:0] = cnt;
            cmp_rd[gi][CNT_W-1:0] = cmp;
        end
        assign ctrl_rd[gi] = {20'd0, div, 4'd0, dbg_stop, mode, en};
        assign int_rd[gi]  = {30'd0, int_en, int_st};
    end

endmodule

// File: tb/tb_timer_mch.sv
`timescale 1ns/1ps
// tb_timer_mch: scenario tasks for the multi-channel timer, expected values from closed-form tick arithmetic.
// Latency: every timed check is expressed as edges elapsed since a write's commit edge.
// Backpressure: none, APB accesses are always two cycles.
module tb_timer_mch;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]  pstrb = 4'h0;
    logic [31:0] pwdata = 32'd0;
    logic [11:0] paddr = 12'd0;
    logic        dbg_mode = 1'b0;

    logic [31:0] prdata, prdata8;
    logic        pready, pready8, pslverr, pslverr8;
    logic [3:0]  tint;
    logic [1:0]  tint8;

    timer_mch #(.N_CH(4), .CNT_W(32)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tim_psel(psel), .tim_penable(penable),
        .tim_pwrite(pwrite), .tim_pstrb(pstrb), .tim_pwdata(pwdata), .tim_paddr(paddr),
        .dbg_mode(dbg_mode), .tim_prdata(prdata), .tim_pready(pready), .tim_pslverr(pslverr),
        .tim_int(tint));

    // Narrow instance sharing the bus, used for the 8-bit wrap case.
    timer_mch #(.N_CH(2), .CNT_W(8)) dut8 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .tim_psel(psel), .tim_penable(penable),
        .tim_pwrite(pwrite), .tim_pstrb(pstrb), .tim_pwdata(pwdata), .tim_paddr(paddr),
        .dbg_mode(dbg_mode), .tim_prdata(prdata8), .tim_pready(pready8), .tim_pslverr(pslverr8),
        .tim_int(tint8));

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc = cyc + 1;

    int   total = 0;
    int   bad = 0;
    bit   sel8 = 1'b0;
    logic [3:0] rd_tint;

    // Tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int k);
        repeat (k) @(posedge sys_clk);
        #1;
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic e, output int ec);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
        @(posedge sys_clk); #1 penable = 1'b1;
        @(negedge sys_clk); e = sel8 ? pslverr8 : pslverr;
        @(posedge sys_clk); #1;
        ec = cyc;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] d, output logic e, output int n);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge sys_clk); #1 penable = 1'b1;
        @(negedge sys_clk);
        d = sel8 ? prdata8 : prdata;
        e = sel8 ? pslverr8 : pslverr;
        rd_tint = sel8 ? {2'b00, tint8} : tint;
        n = cyc;
        @(posedge sys_clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Channel started from CNT=0 at a commit edge; after n edges it has seen n>>div ticks.
    // The (cmp+1)-th tick is the one that finds cnt==cmp.
    function automatic void model(input int mode, input int dv, input longint cmp, input int n,
                                  output longint cnt, output bit ist, output bit en);
        longint t;
        t   = longint'(n >> dv);
        ist = (t > cmp);
        en  = 1'b1;
        case (mode)
            0: cnt = t % 64'h1_0000_0000;
            1: cnt = t % (cmp + 1);
            default: begin
                if (t <= cmp) cnt = t;
                else begin cnt = 0; en = 1'b0; end
            end
        endcase
    endfunction

    logic [31:0] d;
    logic        e;
    int          n, ec, e0;

    task automatic test_reset();
        total++; if (tint !== 4'h0 || tint8 !== 2'h0) begin bad++; $display("FAIL reset_int got=%h/%h exp=0", tint, tint8); end
        total++; if (prdata !== 32'd0 || pready !== 1'b0 || pslverr !== 1'b0) begin
            bad++; $display("FAIL reset_apb_out got=%h/%b/%b exp=0/0/0", prdata, pready, pslverr); end
        sys_rst_n = 1'b1;
        idle(1);
        apb_rd(12'h008, d, e, n);
        total++; if (d !== 32'hFFFF_FFFF || e !== 1'b0) begin bad++; $display("FAIL reset_cmp got=%h err=%b exp=ffffffff", d, e); end
        apb_rd(12'hF00, d, e, n);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_halt got=%h exp=0", d); end
        apb_rd(12'h000, d, e, n);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_ctrl got=%h exp=0", d); end
        sel8 = 1'b1;
        apb_rd(12'h018, d, e, n);
        sel8 = 1'b0;
        total++; if (d !== 32'h0000_00FF) begin bad++; $display("FAIL reset_cmp8 got=%h exp=000000ff", d); end
    endtask

    task automatic test_periodic();
        int rise, expr;
        longint c; bit ist, en;
        apb_wr(12'h018, 32'd4, 4'hF, e, ec);
        apb_wr(12'h01C, 32'h2, 4'hF, e, ec);
        apb_wr(12'h010, 32'h3, 4'hF, e, e0);
        rise = -1;
        for (int k = 0; k < 20 && rise < 0; k++) begin
            @(negedge sys_clk);
            if (tint[1] === 1'b1) rise = cyc;
        end
        idle(0);
        total++; if (rise !== e0 + 5) begin bad++; $display("FAIL periodic_rise got=%0d exp=%0d", rise - e0, 5); end
        for (int k = 0; k < 4; k++) begin
            apb_rd(12'h014, d, e, n);
            model(1, 0, 4, n - e0, c, ist, en);
            total++; if (d !== 32'(c)) begin bad++; $display("FAIL periodic_cnt got=%0d exp=%0d", d, c); end
        end
        // Land the W1C two edges after a match so the clear is not overridden.
        while (((cyc + 2 - e0) % 5) != 2) idle(1);
        apb_wr(12'h01C, 32'h3, 4'hF, e, ec);
        @(negedge sys_clk);
        total++; if (tint[1] !== 1'b0) begin bad++; $display("FAIL periodic_w1c got=%b exp=0", tint[1]); end
        expr = e0 + 5 * ((ec - e0) / 5 + 1);
        rise = -1;
        for (int k = 0; k < 20 && rise < 0; k++) begin
            if (tint[1] === 1'b1) rise = cyc;
            else @(negedge sys_clk);
        end
        idle(0);
        total++; if (rise !== expr) begin bad++; $display("FAIL periodic_rearm got=%0d exp=%0d", rise, expr); end
        apb_wr(12'h010, 32'h0, 4'hF, e, ec);
    endtask

    task automatic test_set_wins();
        apb_wr(12'h028, 32'd0, 4'hF, e, ec);
        apb_wr(12'h02C, 32'h2, 4'hF, e, ec);
        apb_wr(12'h020, 32'h3, 4'hF, e, ec);
        idle(3);
        apb_wr(12'h02C, 32'h3, 4'hF, e, ec);
        apb_rd(12'h02C, d, e, n);
        total++; if (d !== 32'h3 || rd_tint[2] !== 1'b1) begin bad++; $display("FAIL set_wins got=%h int=%b exp=3/1", d, rd_tint[2]); end
        apb_wr(12'h020, 32'h0, 4'hF, e, ec);
    endtask

    task automatic test_oneshot();
        int rise;
        apb_wr(12'h034, 32'd0, 4'hF, e, ec);
        apb_wr(12'h038, 32'd2, 4'hF, e, ec);
        apb_wr(12'h03C, 32'h3, 4'hF, e, ec);
        apb_wr(12'h030, 32'h205, 4'hF, e, e0);
        rise = -1;
        for (int k = 0; k < 40 && rise < 0; k++) begin
            @(negedge sys_clk);
            if (tint[3] === 1'b1) rise = cyc;
        end
        idle(0);
        total++; if (rise !== e0 + 12) begin bad++; $display("FAIL oneshot_rise got=%0d exp=12", rise - e0); end
        apb_rd(12'h034, d, e, n);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL oneshot_cnt got=%h exp=0", d); end
        apb_rd(12'h030, d, e, n);
        total++; if (d !== 32'h204) begin bad++; $display("FAIL oneshot_ctrl got=%h exp=204", d); end
        idle(10);
        apb_rd(12'h03C, d, e, n);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL oneshot_sticky got=%h exp=3", d); end
    endtask

    task automatic test_en_write_wins();
        int ew;
        longint c; bit ist, en;
        apb_wr(12'h03C, 32'h1, 4'hF, e, ec);
        apb_wr(12'h034, 32'd0, 4'hF, e, ec);
        apb_wr(12'h038, 32'd3, 4'hF, e, ec);
        apb_wr(12'h030, 32'h5, 4'hF, e, e0);
        idle(2);
        apb_wr(12'h030, 32'h5, 4'hF, e, ew);  // commits on the one-shot match edge
        apb_rd(12'h030, d, e, n);
        total++; if (d !== 32'h5) begin bad++; $display("FAIL en_write_wins got=%h exp=5", d); end
        apb_rd(12'h03C, d, e, n);
        total++; if (d[0] !== 1'b1) begin bad++; $display("FAIL en_wins_int got=%b exp=1", d[0]); end
        apb_rd(12'h034, d, e, n);
        model(2, 0, 3, n - ew, c, ist, en);
        total++; if (d !== 32'(c)) begin bad++; $display("FAIL en_wins_cnt got=%0d exp=%0d", d, c); end
    endtask

    task automatic test_cnt_write_wins();
        int ew;
        apb_wr(12'h008, 32'd1000, 4'hF, e, ec);
        apb_wr(12'h000, 32'h1, 4'hF, e, e0);
        idle(3);
        apb_wr(12'h004, 32'd100, 4'hF, e, ew);
        apb_rd(12'h004, d, e, n);
        total++; if (d !== 32'(100 + n - ew)) begin bad++; $display("FAIL cnt_write_wins got=%0d exp=%0d", d, 100 + n - ew); end
    endtask

    task automatic test_errors();
        apb_wr(12'h000, 32'h901, 4'hF, e, ec);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL err_div9 got=%b exp=1", e); end
        apb_wr(12'h000, 32'h7, 4'hF, e, ec);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL err_mode3 got=%b exp=1", e); end
        apb_rd(12'h000, d, e, n);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL err_ctrl_kept got=%h exp=1", d); end
        apb_rd(12'h040, d, e, n);
        total++; if (e !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL err_ch_range got=%h err=%b exp=0/1", d, e); end
        apb_rd(12'hF04, d, e, n);
        total++; if (e !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL err_unmapped got=%h err=%b exp=0/1", d, e); end
        apb_wr(12'h028, 32'hAABB_CCDD, 4'hF, e, ec);
        apb_wr(12'h028, 32'h1122_3344, 4'h1, e, ec);
        apb_wr(12'h028, 32'h5566_7788, 4'h0, e, ec);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL err_strb0 got=%b exp=0", e); end
        apb_rd(12'h028, d, e, n);
        total++; if (d !== 32'hAABB_CC44) begin bad++; $display("FAIL strobe_cmp got=%h exp=aabbcc44", d); end
    endtask

    task automatic test_wrap8();
        sel8 = 1'b1;
        apb_wr(12'h000, 32'h0, 4'hF, e, ec);
        apb_wr(12'h004, 32'hABCD_12FE, 4'hF, e, ec);
        apb_wr(12'h00C, 32'h3, 4'hF, e, ec);
        apb_wr(12'h008, 32'hFF, 4'hF, e, ec);
        apb_wr(12'h000, 32'h1, 4'hF, e, e0);
        for (int k = 0; k < 3; k++) begin
            apb_rd(12'h004, d, e, n);
            total++; if (d !== ((32'hFE + 32'(n - e0)) & 32'hFF)) begin
                bad++; $display("FAIL wrap8_cnt got=%h exp=%h", d, (32'hFE + 32'(n - e0)) & 32'hFF); end
        end
        apb_rd(12'h00C, d, e, n);
        total++; if (d !== 32'h3 || rd_tint[0] !== 1'b1) begin bad++; $display("FAIL wrap8_int got=%h line=%b exp=3/1", d, rd_tint[0]); end
        apb_wr(12'h000, 32'h0, 4'hF, e, ec);
        sel8 = 1'b0;
    endtask

    task automatic test_random();
        int ch, mode, dv, cmp, ie;
        longint c; bit ist, en;
        logic [11:0] base;
        for (int it = 0; it < 10; it++) begin
            ch = $urandom_range(3, 0); mode = $urandom_range(2, 0); dv = $urandom_range(3, 0);
            cmp = $urandom_range(5, 0); ie = $urandom_range(1, 0);
            base = 12'(ch * 16);
            apb_wr(base, 32'h0, 4'hF, e, ec);
            apb_wr(base + 12'h4, 32'h0, 4'hF, e, ec);
            apb_wr(base + 12'hC, 32'(ie * 2 + 1), 4'hF, e, ec);
            apb_wr(base + 12'h8, 32'(cmp), 4'hF, e, ec);
            apb_wr(base, 32'(dv * 256 + mode * 2 + 1), 4'hF, e, e0);
            idle($urandom_range(20, 0));
            apb_rd(base + 12'h4, d, e, n);
            model(mode, dv, cmp, n - e0, c, ist, en);
            total++; if (d !== 32'(c)) begin bad++; $display("FAIL rnd_cnt ch=%0d m=%0d got=%0d exp=%0d", ch, mode, d, c); end
            apb_rd(base + 12'hC, d, e, n);
            model(mode, dv, cmp, n - e0, c, ist, en);
            total++; if (d !== 32'(ie * 2 + int'(ist)) || rd_tint[ch] !== (ist & ie[0])) begin
                bad++; $display("FAIL rnd_int ch=%0d got=%h line=%b exp=%0d", ch, d, rd_tint[ch], ie * 2 + int'(ist)); end
            apb_rd(base, d, e, n);
            model(mode, dv, cmp, n - e0, c, ist, en);
            total++; if (d !== 32'(dv * 256 + mode * 2 + int'(en))) begin
                bad++; $display("FAIL rnd_ctrl ch=%0d got=%h exp=%h", ch, d, dv * 256 + mode * 2 + int'(en)); end
        end
    endtask

    task automatic test_halt();
        int e1, eh, ed, fz;
        dbg_mode = 1'b1;
        apb_wr(12'h000, 32'h0, 4'hF, e, ec);
        apb_wr(12'h004, 32'h0, 4'hF, e, ec);
        apb_wr(12'h008, 32'hFFFF_FFFF, 4'hF, e, ec);
        apb_wr(12'h000, 32'h9, 4'hF, e, e0);
        apb_wr(12'h010, 32'h0, 4'hF, e, ec);
        apb_wr(12'h018, 32'hFFFF_FFFF, 4'hF, e, ec);
        apb_wr(12'h014, 32'h0, 4'hF, e, ec);
        apb_wr(12'h010, 32'h1, 4'hF, e, e1);
        apb_wr(12'hF00, 32'h1, 4'hF, e, eh);
        apb_rd(12'hF00, d, e, n);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL halt_ack got=%h exp=3", d); end
        fz = eh + 1 - e0;
        apb_rd(12'h004, d, e, n);
        total++; if (d !== 32'(fz)) begin bad++; $display("FAIL halt_frozen got=%0d exp=%0d", d, fz); end
        apb_rd(12'h014, d, e, n);
        total++; if (d !== 32'(n - e1)) begin bad++; $display("FAIL halt_ch1_runs got=%0d exp=%0d", d, n - e1); end
        apb_rd(12'h004, d, e, n);
        total++; if (d !== 32'(fz)) begin bad++; $display("FAIL halt_still_frozen got=%0d exp=%0d", d, fz); end
        dbg_mode = 1'b0;
        ed = cyc;
        apb_rd(12'hF00, d, e, n);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL halt_ack_drop got=%h exp=1", d); end
        apb_rd(12'h004, d, e, n);
        total++; if (d !== 32'(fz + n - (ed + 1))) begin bad++; $display("FAIL halt_resume got=%0d exp=%0d", d, fz + n - (ed + 1)); end
        apb_wr(12'hF00, 32'h0, 4'hF, e, ec);
    endtask

    task automatic test_reset_mid();
        apb_wr(12'h028, 32'd0, 4'hF, e, ec);
        apb_wr(12'h02C, 32'h2, 4'hF, e, ec);
        apb_wr(12'h020, 32'h3, 4'hF, e, ec);
        idle(2);
        total++; if (tint[2] !== 1'b1) begin bad++; $display("FAIL mid_pre_int got=%b exp=1", tint[2]); end
        sys_rst_n = 1'b0;
        #1;
        total++; if (tint !== 4'h0) begin bad++; $display("FAIL mid_reset_int got=%h exp=0", tint); end
        idle(1);
        sys_rst_n = 1'b1;
        idle(1);
        apb_rd(12'h024, d, e, n);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_reset_cnt got=%h exp=0", d); end
        apb_rd(12'h028, d, e, n);
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mid_reset_cmp got=%h exp=ffffffff", d); end
        apb_rd(12'h020, d, e, n);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_reset_ctrl got=%h exp=0", d); end
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        test_reset();
        test_periodic();
        test_set_wins();
        test_oneshot();
        test_en_write_wins();
        test_cnt_write_wins();
        test_errors();
        test_wrap8();
        test_random();
        test_halt();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_mch.md
# timer_mch

Multi-channel APB timer: a parametrised successor to the single 64-bit timer. It provides N_CH independent counters of CNT_W bits, each with its own power-of-two prescaler, compare register, and mode (free-run, periodic auto-reload or one-shot). Each channel has a sticky interrupt and drives its own interrupt line. A shared debug-halt handshake lets selected channels freeze. The block is an APB slave on the peripheral bus.

## Interface
- N_CH, 4, channel count, 1..8
- CNT_W, 32, counter/compare width, 8..32
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- tim_psel  in  1  APB select
- tim_penable  in  1  APB enable
- tim_pwrite  in  1  1 = write
- tim_pstrb  in  4  write byte strobes
- tim_pwdata  in  32  write data
- tim_paddr  in  12  byte address, bits [1:0] ignored
- dbg_mode  in  1  debug mode from core
- tim_prdata  out  32  read data
- tim_pready  out  1  APB ready
- tim_pslverr  out  1  APB error
- tim_int  out  N_CH  per-channel interrupt, level

## Operation
- Channel i register base is 0x10*i. Offsets:
  - 0x0 CTRL: [0] EN, [2:1] MODE (00 free-run, 01 periodic, 10 one-shot, 11 illegal), [3] DBG_STOP, [11:8] DIV (0..8)
  - 0x4 CNT: RW
  - 0x8 CMP: RW
  - 0xC INT: [0] INT_ST, W1C; [1] INT_EN, RW
- Global register 0xF00 HALT: [0] HALT_REQ RW, [1] HALT_ACK RO.
- Reset values: CTRL=0, CNT=0, CMP=all ones (CNT_W bits), INT=0, HALT=0.
- Registers narrower than 32 bits read zero in unused bits. Write bits above CNT_W are dropped.
- Byte strobes apply to every RW register. pstrb=0 is a legal no-op write.
- Prescaler: each channel has its own divider counter. tick = EN & ~frozen & (div_cnt == 2^DIV−1). div_cnt is cleared when EN=0, when frozen, and on any CTRL write. DIV=0 gives a tick every cycle.
- On a tick, with cnt == CMP:
  - set INT_ST
  - free-run: cnt+1, wrapping modulo 2^CNT_W
  - periodic: cnt ← 0
  - one-shot: cnt ← 0 and EN ← 0
- On a tick with no match: cnt ← cnt+1, wrapping.
- tim_int[i] = INT_ST & INT_EN.
- Halt: HALT_ACK = registered (HALT_REQ & dbg_mode). A channel is frozen when HALT_ACK & DBG_STOP. Frozen channels hold CNT and the divider. APB access stays fully functional while frozen.
- Error (tim_pslverr=1, write has no effect, read returns 0) on any of:
  - channel index ≥ N_CH
  - unmapped offset
  - CTRL write with DIV>8 or MODE=11
- Simultaneous events:
  - APB write to CNT in the same cycle as a tick: the write wins.
  - W1C of INT_ST in the same cycle as a set: the set wins.
  - APB write of EN=1 in the same cycle as the one-shot auto-clear: the write wins.

## Timing
- APB has no wait states. tim_pready = tim_psel & tim_penable.
- tim_prdata and tim_pslverr are valid in the access cycle. Both are 0 outside an access.
- Writes commit at the rising edge ending the access phase. A read in the following access returns the new value.
- CNT changes one cycle after the tick condition. INT_ST and tim_int rise on the same edge as the match update.
- HALT_ACK follows HALT_REQ & dbg_mode with 1 cycle latency, in both directions.
- Periodic period = (CMP+1)·2^DIV cycles. CMP=0 in periodic mode interrupts every tick.
- Asserting reset mid-operation returns all state to reset values immediately. Outputs are 0 during reset.

## Test plan
- Reset check: all outputs 0; read ch0 CMP = 0xFFFF_FFFF (CNT_W=32); read HALT = 0.
- Periodic DIV=0: ch1 CMP=4, MODE=01, EN=1, INT_EN=1.
  - Expect tim_int[1] to rise 5 cycles after EN commit.
  - CNT sequence 0,1,2,3,4,0.
  - W1C INT clears tim_int; it re-asserts 5 cycles later.
- One-shot DIV=2: CMP=2. Expect match after 12 cycles, then CNT=0, CTRL.EN reads 0, INT_ST=1 and sticky.
- Free-run wrap: CNT_W=8, CNT written 0xFE, CMP=0xFF. Expect 0xFF, then INT_ST=1 and CNT=0x00 (wrap).
- Errors:
  - write CTRL DIV=9 → pslverr=1, CTRL unchanged
  - read channel N_CH → pslverr=1, prdata=0
  - pstrb=4'b0001 to CMP changes only byte 0
- Debug halt: ch0 DBG_STOP=1, ch1 DBG_STOP=0, HALT_REQ=1, dbg_mode=1.
  - HALT_ACK=1 one cycle later; ch0 CNT frozen, ch1 counting.
  - dbg_mode=0 → ch0 resumes after 1 cycle.
